// File: rtl/cube_scan_sequencer.sv
// Scans one 8x8x8 frame out of the cube stream buffer layer by layer:
// blank, load eight column latches, then light the layer for a fixed dwell.
module cube_scan_sequencer #(
  parameter int DWELL_CYCLES = 2000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       frame_swap_req,
  output logic [5:0] frame_addr,
  output logic [7:0] latch_data,
  output logic [7:0] latch_sel,
  output logic       latch_stb,
  output logic [7:0] layer_en,
  output logic       oe_n,
  output logic       scan_done,
  output logic       frame_swap_ack
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    LOAD_ADDR,
    LOAD_STB,
    DWELL
  } state_t;

  state_t        state, state_next;
  logic [2:0]    layer, layer_next;
  logic [2:0]    col, col_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    latch_data_next;
  logic          scan_done_next;
  logic          ack_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      layer          <= 3'd0;
      col            <= 3'd0;
      cnt            <= '0;
      latch_data     <= 8'd0;
      scan_done      <= 1'b0;
      frame_swap_ack <= 1'b0;
    end else begin
      state          <= state_next;
      layer          <= layer_next;
      col            <= col_next;
      cnt            <= cnt_next;
      latch_data     <= latch_data_next;
      scan_done      <= scan_done_next;
      frame_swap_ack <= ack_next;
    end
  end

  always_comb begin
    state_next      = state;
    layer_next      = layer;
    col_next        = col;
    cnt_next        = cnt;
    latch_data_next = latch_data;
    scan_done_next  = 1'b0;
    ack_next        = 1'b0;
    frame_addr      = 6'd0;
    latch_sel       = 8'd0;
    latch_stb       = 1'b0;
    layer_en        = 8'd0;
    oe_n            = 1'b1;

    case (state)
      IDLE: begin
        layer_next      = 3'd0;
        col_next        = 3'd0;
        cnt_next        = '0;
        latch_data_next = 8'd0;
        if (enable) state_next = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_next   = '0;
          col_next   = 3'd0;
          state_next = LOAD_ADDR;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOAD_ADDR: begin
        frame_addr      = {layer, col};
        latch_data_next = data_in;
        state_next      = LOAD_STB;
      end
      LOAD_STB: begin
        frame_addr = {layer, col};
        latch_stb  = 1'b1;
        latch_sel  = 8'd1 << col;
        if (col == 3'd7) begin
          state_next = DWELL;
        end else begin
          col_next   = col + 3'd1;
          state_next = LOAD_ADDR;
        end
      end
      DWELL: begin
        layer_en = 8'd1 << layer;
        oe_n     = 1'b0;
        if (cnt == DWELL_LAST) begin
          cnt_next   = '0;
          layer_next = layer + 3'd1;
          state_next = BLANK;
          // Swaps are only granted here so a displayed frame is never torn.
          if (layer == 3'd7) begin
            scan_done_next = 1'b1;
            ack_next       = frame_swap_req;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state != IDLE && !enable) begin
      state_next      = IDLE;
      layer_next      = 3'd0;
      col_next        = 3'd0;
      cnt_next        = '0;
      latch_data_next = 8'd0;
      scan_done_next  = 1'b0;
      ack_next        = 1'b0;
    end
  end

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Self-checking bench for cube_scan_sequencer: a timeline model derives every
// output from elapsed scan time, plus directed checks from the scan timing rules.
module tb_cube_scan_sequencer;

  localparam int DWELL  = 8;
  localparam int BLANK  = 2;
  localparam int PERIOD = BLANK + 16 + DWELL;
  localparam int SCAN   = 8 * PERIOD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_swap_req = 1'b0;
  logic [7:0] data_in;
  logic [5:0] frame_addr;
  logic [7:0] latch_data;
  logic [7:0] latch_sel;
  logic       latch_stb;
  logic [7:0] layer_en;
  logic       oe_n;
  logic       scan_done;
  logic       frame_swap_ack;

  int errors = 0;
  int checks = 0;

  logic [7:0] frames [2][64];
  logic       bench_frame = 1'b0;

  cube_scan_sequencer #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .data_in(data_in),
    .frame_swap_req(frame_swap_req),
    .frame_addr(frame_addr),
    .latch_data(latch_data),
    .latch_sel(latch_sel),
    .latch_stb(latch_stb),
    .layer_en(layer_en),
    .oe_n(oe_n),
    .scan_done(scan_done),
    .frame_swap_ack(frame_swap_ack)
  );

  always #5 clk = ~clk;

  assign data_in = frames[bench_frame][frame_addr];

  // Upstream buffer: flips to the other frame once a swap is granted.
  always @(posedge clk) if (frame_swap_ack) bench_frame <= ~bench_frame;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic req_v);
    rst_n = rst_v;
    enable = en_v;
    frame_swap_req = req_v;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
    if (frame_swap_ack) frame_swap_req = 1'b0;
  endtask

  // Timeline model: m_t counts cycles since the scan (re)started.
  bit   m_valid = 0;
  bit   m_active = 0;
  int   m_t = 0;
  bit   m_done = 0;
  bit   m_ack = 0;
  logic m_frame = 1'b0;

  always @(posedge clk) begin
    m_done = 0;
    m_ack = 0;
    if (!rst_n) m_valid = 1;
    if (!rst_n || !enable) begin
      m_active = 0;
      m_t = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_t = 0;
    end else begin
      m_t++;
      if (m_t % SCAN == 0) begin
        m_done = 1;
        m_ack = frame_swap_req;
        if (frame_swap_req) m_frame = ~m_frame;
      end
    end
  end

  always @(negedge clk) begin
    int s, ly, ph, k, c;
    int exp_le, exp_oe, exp_stb, exp_sel, exp_addr, exp_data;
    bit chk_addr, chk_data;
    if (m_valid) begin
      exp_le = 0; exp_oe = 1; exp_stb = 0; exp_sel = 0;
      exp_addr = 0; exp_data = 0; chk_addr = 0; chk_data = 0;
      if (!m_active) begin
        chk_addr = 1;
        chk_data = 1;
      end else begin
        s  = m_t % SCAN;
        ly = s / PERIOD;
        ph = s % PERIOD;
        if (ph >= BLANK && ph < BLANK + 16) begin
          k = ph - BLANK;
          c = k / 2;
          chk_addr = 1;
          exp_addr = ly * 8 + c;
          if (k % 2 == 1) begin
            exp_stb  = 1;
            exp_sel  = 1 << c;
            chk_data = 1;
            exp_data = frames[m_frame][ly * 8 + c];
          end
        end else if (ph >= BLANK + 16) begin
          exp_le = 1 << ly;
          exp_oe = 0;
        end
      end
      checkOutput("layer_en", layer_en, exp_le);
      checkOutput("oe_n", oe_n, exp_oe);
      checkOutput("latch_stb", latch_stb, exp_stb);
      checkOutput("latch_sel", latch_sel, exp_sel);
      checkOutput("scan_done", scan_done, m_done);
      checkOutput("frame_swap_ack", frame_swap_ack, m_ack);
      if (chk_addr) checkOutput("frame_addr", frame_addr, exp_addr);
      if (chk_data) checkOutput("latch_data", latch_data, exp_data);
      checkOutput("inv_stb_oe", latch_stb && !oe_n, 0);
      checkOutput("inv_onehot", $countones(layer_en) <= 1, 1);
      checkOutput("inv_oe_layer", (!oe_n) == (layer_en != 8'd0), 1);
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_layer_en"}, layer_en, 0);
    checkOutput({tag, "_oe_n"}, oe_n, 1);
    checkOutput({tag, "_latch_stb"}, latch_stb, 0);
    checkOutput({tag, "_latch_sel"}, latch_sel, 0);
    checkOutput({tag, "_latch_data"}, latch_data, 0);
    checkOutput({tag, "_frame_addr"}, frame_addr, 0);
    checkOutput({tag, "_scan_done"}, scan_done, 0);
    checkOutput({tag, "_ack"}, frame_swap_ack, 0);
  endtask

  initial begin
    int done_cyc[$];
    logic [7:0] le_seq[$];
    logic [7:0] last_le;
    int stb_idx, l3_cycles, guard, acks, r;
    bit found, seen_stb;

    for (int a = 0; a < 64; a++) begin
      frames[0][a] = 8'(a);
      frames[1][a] = {2'b11, 6'($urandom)};
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkResetOutputs("reset");

    // Three uninterrupted scans from identity frame.
    applyStimulus(1'b1, 1'b1, 1'b0);
    stb_idx = 0; l3_cycles = 0; last_le = 8'd0;
    for (int c = 1; c <= 3 * SCAN + 5; c++) begin
      stepCycle();
      if (scan_done) done_cyc.push_back(c);
      if (c <= SCAN) begin
        if (latch_stb) begin
          checkOutput("scan1_sel", latch_sel, 8'h01 << (stb_idx % 8));
          if (stb_idx >= 24 && stb_idx < 32)
            checkOutput("layer3_data", latch_data, 8'h18 + stb_idx - 24);
          stb_idx++;
        end
        if (layer_en == 8'h08) l3_cycles++;
      end
      if (layer_en != 8'd0 && layer_en != last_le) begin
        le_seq.push_back(layer_en);
        last_le = layer_en;
      end
    end
    checkOutput("scan1_strobes", stb_idx, 64);
    checkOutput("layer3_dwell", l3_cycles, 8);
    checkOutput("done_count", done_cyc.size(), 3);
    if (done_cyc.size() >= 3) begin
      checkOutput("done0_cycle", done_cyc[0], 209);
      checkOutput("done1_cycle", done_cyc[1], 417);
      checkOutput("done2_cycle", done_cyc[2], 625);
    end
    checkOutput("le_seq_len", le_seq.size() >= 9, 1);
    if (le_seq.size() >= 9) begin
      for (int i = 0; i < 8; i++) checkOutput("le_seq", le_seq[i], 8'h01 << i);
      checkOutput("le_wrap", le_seq[8], 8'h01);
    end

    // Frame swap requested during layer 2 dwell.
    found = 0;
    for (guard = 0; guard < 2 * SCAN && !found; guard++) begin
      stepCycle();
      if (layer_en == 8'h04) found = 1;
    end
    checkOutput("wait_layer2", found, 1);
    frame_swap_req = 1'b1;
    found = 0;
    for (guard = 0; guard < SCAN + 10 && !found; guard++) begin
      stepCycle();
      if (frame_swap_ack) begin
        found = 1;
        checkOutput("ack_with_done", scan_done, 1);
      end
    end
    checkOutput("ack_seen", found, 1);
    acks = 0; seen_stb = 0;
    for (int c = 0; c < SCAN; c++) begin
      stepCycle();
      if (frame_swap_ack) acks++;
      if (latch_stb && !seen_stb) begin
        seen_stb = 1;
        checkOutput("new_frame_byte0", latch_data, frames[1][0]);
      end
    end
    checkOutput("extra_acks", acks, 0);

    // Drop enable on the 4th strobe of layer 5.
    found = 0;
    for (guard = 0; guard < 2 * SCAN && !found; guard++) begin
      stepCycle();
      if (latch_stb && latch_sel == 8'h08 && frame_addr[5:3] == 3'd5) found = 1;
    end
    checkOutput("wait_l5_stb4", found, 1);
    enable = 1'b0;
    stepCycle();
    checkResetOutputs("disable");
    repeat (3) stepCycle();
    enable = 1'b1;
    repeat (2) begin
      stepCycle();
      checkOutput("reen_blank_oe", oe_n, 1);
      checkOutput("reen_blank_stb", latch_stb, 0);
    end
    stepCycle();
    checkOutput("reen_addr", frame_addr, 0);
    stepCycle();
    checkOutput("reen_stb", latch_stb, 1);
    checkOutput("reen_sel", latch_sel, 8'h01);
    checkOutput("reen_data", latch_data, frames[1][0]);

    // One-cycle reset during layer 7 dwell while a swap is pending.
    found = 0;
    for (guard = 0; guard < 2 * SCAN && !found; guard++) begin
      stepCycle();
      if (layer_en == 8'h80) found = 1;
    end
    checkOutput("wait_layer7", found, 1);
    frame_swap_req = 1'b1;
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    checkResetOutputs("midreset");
    applyStimulus(1'b1, 1'b1, 1'b0);
    acks = 0; last_le = 8'd0;
    for (int c = 0; c < SCAN + PERIOD; c++) begin
      stepCycle();
      if (frame_swap_ack) acks++;
      if (last_le == 8'd0 && layer_en != 8'd0) last_le = layer_en;
    end
    checkOutput("post_reset_acks", acks, 0);
    checkOutput("post_reset_layer", last_le, 8'h01);

    // Randomized enable, request and reset traffic.
    for (int c = 0; c < 3000; c++) begin
      stepCycle();
      r = $urandom_range(0, 999);
      rst_n = (r != 5);
      if (r < 4) enable = ~enable;
      if (!frame_swap_req && r >= 900 && r < 915) frame_swap_req = 1'b1;
      else if (frame_swap_req && r >= 990) frame_swap_req = 1'b0;
    end

    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3 * SCAN + 20) stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
